// File: rtl/uart_mult_byte_tx_pkg.sv
// Shared definitions for the multi-byte UART packet link: header value, CRC8 and
// FSM state encodings used by both the transmitter and the receiver checker.
package uart_pkt_defs;

   localparam logic [7:0] PKT_HEAD  = 8'hA5;
   localparam logic [7:0] CRC8_POLY = 8'h07;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_HEAD = 3'd1;
   localparam logic [2:0] ST_LEN  = 3'd2;
   localparam logic [2:0] ST_DATA = 3'd3;
   localparam logic [2:0] ST_CRC  = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   // CRC8, non-reflected, no final XOR; one whole byte per call
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int unsigned i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser, LSB first. byte_done is combinational in the last cycle of the
// stop bit so the sequencer can load the next byte with no gap on the line.
module uart_byte_tx #(
   parameter int unsigned _BPS_CNT = 434
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       byte_load,
   input  logic [7:0] byte_data,
   output logic       byte_done,
   output logic       uart_txd
);

   localparam int unsigned     BPS_W    = (_BPS_CNT > 1) ? $clog2(_BPS_CNT) : 1;
   localparam logic [BPS_W-1:0] BPS_LAST = BPS_W'(_BPS_CNT - 1);

   logic             active;
   logic [BPS_W-1:0] bps_cnt;
   logic [3:0]       bit_cnt;
   logic [7:0]       shift_q;
   logic             bit_end;

   assign bit_end   = active && (bps_cnt == BPS_LAST);
   assign byte_done = bit_end && (bit_cnt == 4'd9);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         active   <= 1'b0;
         bps_cnt  <= '0;
         bit_cnt  <= '0;
         shift_q  <= '0;
         uart_txd <= 1'b1;
      end else if (byte_load) begin
         active   <= 1'b1;
         bps_cnt  <= '0;
         bit_cnt  <= '0;
         shift_q  <= byte_data;
         uart_txd <= 1'b0;
      end else if (active) begin
         if (bit_end) begin
            bps_cnt <= '0;
            if (bit_cnt == 4'd9) begin
               active  <= 1'b0;
               bit_cnt <= '0;
            end else begin
               // bit_cnt 0..7 -> data bit bit_cnt next, 8 -> stop bit next
               bit_cnt  <= bit_cnt + 4'd1;
               uart_txd <= (bit_cnt == 4'd8) ? 1'b1 : shift_q[bit_cnt[2:0]];
            end
         end else begin
            bps_cnt <= bps_cnt + BPS_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Packet transmitter: frames HEAD, LEN, payload, CRC8 and hands bytes back-to-back to
// the 8N1 serialiser. CRC covers LEN and payload and is updated as each byte is loaded.
module uart_mult_byte_tx
   import uart_pkt_defs::*;
#(
   parameter int unsigned _CLK_FREQ  = 50_000_000,
   parameter int unsigned _BAUD      = 115200,
   parameter int unsigned _MAX_BYTES = 11,
   parameter logic [7:0]  _HEAD      = PKT_HEAD
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   input  logic                    pkt_start,
   input  logic [7:0]              pkt_len,
   input  logic [_MAX_BYTES*8-1:0] pkt_data,
   output logic                    busy,
   output logic                    pkt_done,
   output logic                    uart_txd
);

   localparam int unsigned BPS_CNT = _CLK_FREQ / _BAUD;
   localparam int unsigned IDX_W   = (_MAX_BYTES > 1) ? $clog2(_MAX_BYTES) : 1;
   localparam logic [7:0]  MAX_LEN = 8'(_MAX_BYTES);

   logic [2:0]       state;
   logic [7:0]       len_q;
   logic [7:0]       crc_q;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] next_idx;
   logic [7:0]       data_q [_MAX_BYTES];
   logic             last_data;
   logic             byte_load;
   logic             byte_done;
   logic             load_crc;
   logic [7:0]       byte_data;

   assign next_idx  = idx + IDX_W'(1);
   assign last_data = (8'(idx) == (len_q - 8'd1));
   assign busy      = (state == ST_HEAD) || (state == ST_LEN) ||
                      (state == ST_DATA) || (state == ST_CRC);
   assign pkt_done  = (state == ST_DONE);

   // Next byte is selected in the cycle byte_done fires, so it starts on the following edge
   always_comb begin
      byte_load = 1'b0;
      byte_data = _HEAD;
      load_crc  = 1'b0;
      case (state)
         ST_IDLE: byte_load = pkt_start;
         ST_HEAD: begin
            byte_load = byte_done;
            byte_data = len_q;
         end
         ST_LEN: begin
            byte_load = byte_done;
            if (len_q == 8'd0) begin
               load_crc  = 1'b1;
               byte_data = crc_q;
            end else begin
               byte_data = data_q[0];
            end
         end
         ST_DATA: begin
            byte_load = byte_done;
            if (last_data) begin
               load_crc  = 1'b1;
               byte_data = crc_q;
            end else begin
               byte_data = data_q[next_idx];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= ST_IDLE;
         len_q <= '0;
         crc_q <= '0;
         idx   <= '0;
         for (int unsigned k = 0; k < _MAX_BYTES; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         // HEAD load clears the CRC; HEAD itself is not covered
         if (byte_load && !load_crc) begin
            crc_q <= (state == ST_IDLE) ? 8'h00 : crc8_byte(crc_q, byte_data);
         end
         case (state)
            ST_IDLE: begin
               if (pkt_start) begin
                  len_q <= (pkt_len > MAX_LEN) ? MAX_LEN : pkt_len;
                  for (int unsigned k = 0; k < _MAX_BYTES; k++) begin
                     data_q[k] <= pkt_data[8*k +: 8];
                  end
                  idx   <= '0;
                  state <= ST_HEAD;
               end
            end
            ST_HEAD: if (byte_done) state <= ST_LEN;
            ST_LEN: begin
               if (byte_done) begin
                  idx   <= '0;
                  state <= (len_q == 8'd0) ? ST_CRC : ST_DATA;
               end
            end
            ST_DATA: begin
               if (byte_done) begin
                  if (last_data) state <= ST_CRC;
                  else           idx   <= next_idx;
               end
            end
            ST_CRC:  if (byte_done) state <= ST_DONE;
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   uart_byte_tx #(
      ._BPS_CNT (BPS_CNT)
   ) u_byte_tx (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .byte_load (byte_load),
      .byte_data (byte_data),
      .byte_done (byte_done),
      .uart_txd  (uart_txd)
   );

endmodule
